jacobi_result_unloader: RTL and testbench

//  Reads the converged Jacobi result memory after a sweep finishes and streams it out on a valid/ready port.

---
 rtl/jacobi_result_unloader.sv | 207 ++++++++++++++++++++
 tb/tb_jacobi_result_unloader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_result_unloader.sv
// Streams the converged Jacobi results out of the result RAM: the 8 diagonal eigenvalues first, then V row-major.
// Optional build macro JACOBI_UNLOAD_SAT_EN clamps every word to the Q(1.0.15) range before it enters the output buffer.
module jacobi_result_unloader #(
    parameter int N        = 8,
    parameter int WORD_W   = 20,
    parameter int ADDR_W   = 7,
    parameter int V_OFFSET = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [WORD_W-1:0] mem_rd_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [WORD_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              m_is_vec_o
);

    localparam int TOTAL = N + N * N;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE_S, DIAG_S, VEC_S, DRAIN_S} state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    rd_cnt_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic [ADDR_W-1:0]   diag_addr_r;
    logic [ADDR_W-1:0]   diag_step_r;
    logic                inflight_r;
    logic [1:0]          fifo_cnt_r;
    logic [WORD_W-1:0]   fifo_head_r;
    logic [WORD_W-1:0]   fifo_tail_r;
    logic                done_r;
    logic                issue_s;
    logic                pop_s;
    logic                last_beat_s;
    logic                room_s;
    logic [2:0]          occ_after_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [WORD_W-1:0]   push_word_s;

    function automatic logic [WORD_W-1:0] fifo_word(input logic [WORD_W-1:0] w);
`ifdef JACOBI_UNLOAD_SAT_EN
        logic signed [WORD_W-1:0] s;
        logic signed [WORD_W-1:0] sat_max;
        logic signed [WORD_W-1:0] sat_min;
        s       = signed'(w);
        sat_max = WORD_W'(32'sd32767);
        sat_min = WORD_W'(-32'sd32768);
        if (s > sat_max) begin
            return sat_max;
        end else if (s < sat_min) begin
            return sat_min;
        end else begin
            return w;
        end
`else
        return w;
`endif
    endfunction

    assign pop_s       = (fifo_cnt_r != 2'd0) && m_ready_i;
    assign last_beat_s = pop_s && (beat_cnt_r == CNT_W'(TOTAL - 1));
    // Occupancy counted after this cycle's pop so a steady stream keeps one read per cycle.
    assign occ_after_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign room_s      = occ_after_s < 3'd2;
    assign push_word_s = fifo_word(mem_rd_data_i);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE_S;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: phases advance on the read that completes each region.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE_S:  if (issue_s) next_state_s = DIAG_S; else next_state_s = IDLE_S;
            DIAG_S:  if (issue_s && (rd_cnt_r == CNT_W'(N - 1))) next_state_s = VEC_S; else next_state_s = DIAG_S;
            VEC_S:   if (issue_s && (rd_cnt_r == CNT_W'(TOTAL - 1))) next_state_s = DRAIN_S; else next_state_s = VEC_S;
            DRAIN_S: if (last_beat_s) next_state_s = IDLE_S; else next_state_s = DRAIN_S;
            default: next_state_s = IDLE_S;
        endcase
    end

    // Output logic: the first read goes out in the start cycle to reach a 2-cycle first-beat latency.
    always_comb begin
        issue_s   = 1'b0;
        rd_addr_s = '0;
        case (state_r)
            IDLE_S: begin
                issue_s   = start_i && room_s;
                rd_addr_s = '0;
            end
            DIAG_S: begin
                issue_s   = room_s;
                rd_addr_s = diag_addr_r;
            end
            VEC_S: begin
                issue_s   = room_s;
                rd_addr_s = ADDR_W'(V_OFFSET) + ADDR_W'(rd_cnt_r) - ADDR_W'(N);
            end
            DRAIN_S: begin
                issue_s   = 1'b0;
                rd_addr_s = '0;
            end
            default: begin
                issue_s   = 1'b0;
                rd_addr_s = '0;
            end
        endcase
    end

    // Read/beat counters and incremental diagonal address (step shrinks by one per row).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r    <= '0;
            beat_cnt_r  <= '0;
            diag_addr_r <= '0;
            diag_step_r <= '0;
            inflight_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            done_r     <= last_beat_s;
            if (last_beat_s) begin
                rd_cnt_r <= '0;
            end else if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + CNT_W'(1);
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
            if (last_beat_s) begin
                beat_cnt_r <= '0;
            end else if (pop_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (issue_s && (state_r == IDLE_S)) begin
                diag_addr_r <= ADDR_W'(N);
                diag_step_r <= ADDR_W'(N - 1);
            end else if (issue_s && (state_r == DIAG_S)) begin
                diag_addr_r <= diag_addr_r + diag_step_r;
                diag_step_r <= diag_step_r - ADDR_W'(1);
            end else begin
                diag_addr_r <= diag_addr_r;
                diag_step_r <= diag_step_r;
            end
        end
    end

    // Two-entry output FIFO; RAM data lands here the cycle after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_r  <= 2'd0;
            fifo_head_r <= '0;
            fifo_tail_r <= '0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (fifo_cnt_r == 2'd0) begin
                        fifo_head_r <= push_word_s;
                    end else begin
                        fifo_tail_r <= push_word_s;
                    end
                    fifo_cnt_r <= fifo_cnt_r + 2'd1;
                end
                2'b01: begin
                    fifo_head_r <= fifo_tail_r;
                    fifo_cnt_r  <= fifo_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_r == 2'd1) begin
                        fifo_head_r <= push_word_s;
                    end else begin
                        fifo_head_r <= fifo_tail_r;
                        fifo_tail_r <= push_word_s;
                    end
                end
                default: begin
                    fifo_cnt_r <= fifo_cnt_r;
                end
            endcase
        end
    end

    assign busy_o        = (state_r != IDLE_S);
    assign done_o        = done_r;
    assign mem_rd_en_o   = issue_s;
    assign mem_rd_addr_o = rd_addr_s;
    assign m_valid_o     = (fifo_cnt_r != 2'd0);
    assign m_data_o      = fifo_head_r;
    assign m_last_o      = (beat_cnt_r == CNT_W'(TOTAL - 1)) && m_valid_o;
    assign m_is_vec_o    = (beat_cnt_r >= CNT_W'(N));

endmodule

// File: tb/tb_jacobi_result_unloader.sv
// Scoreboard bench for jacobi_result_unloader: expected beats are queued at start, a monitor checks every handshake.
module tb_jacobi_result_unloader;
    localparam int W     = 20;
    localparam int AW    = 7;
    localparam int TOTAL = 72;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
        logic         vec;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic          ready_val = 1'b0;
    logic          ready_tog = 1'b0;
    logic          busy, done, rd_en, valid, last, is_vec;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  data;
    logic [W-1:0]  ram [0:127];
    int            cyc = 0;
    int            checks = 0;
    int            fails = 0;
    int            hs_total = 0;
    int            run_base = 0;
    int            first_hs = 0;
    int            last_hs = 0;
    int            rd_issued = 0;
    int            start_cyc = 0;
    int            diag_tab [8] = '{0, 8, 15, 21, 26, 30, 33, 35};
    beat_t         q [$];

    jacobi_result_unloader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr), .mem_rd_data_i(rd_data),
        .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data), .m_last_o(last), .m_is_vec_o(is_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    always @(posedge clk) begin
        #1;
        if (ready_tog) ready = ~ready;
        else ready = ready_val;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        logic         exp_done = 1'b0;
        logic         stall_pend = 1'b0;
        logic [W-1:0] stall_data = '0;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (rd_en) rd_issued++;
            if (!rst_n) begin
                exp_done   = 1'b0;
                stall_pend = 1'b0;
            end else begin
                if (exp_done || done) chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
                exp_done = 1'b0;
                if (stall_pend) begin
                    chk("hold_valid", {31'd0, valid}, 32'd1);
                    chk("hold_data", {12'd0, data}, {12'd0, stall_data});
                end
                if (valid && ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_beat: got %0h expected none", data);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", {12'd0, data}, {12'd0, e.d});
                        chk("beat_last", {31'd0, last}, {31'd0, e.last});
                        chk("beat_is_vec", {31'd0, is_vec}, {31'd0, e.vec});
                        exp_done = e.last;
                    end
                    if (hs_total == run_base) first_hs = cyc;
                    last_hs = cyc;
                    hs_total++;
                end
                stall_pend = valid && !ready;
                stall_data = data;
            end
        end
    endtask

    task automatic push_run();
        beat_t e;
        int    a;
        for (int k = 0; k < TOTAL; k++) begin
            a      = (k < 8) ? diag_tab[k] : 36 + k - 8;
            e.d    = ram[a];
            e.last = (k == TOTAL - 1);
            e.vec  = (k >= 8);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", nm);
        end
        chk({nm, "_queue_empty"}, q.size(), 32'd0);
        chk({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
        q.delete();
    endtask

    task automatic wait_beats(input int cnt);
        int n = 0;
        while ((hs_total - run_base) < cnt && n < 400) begin
            @(negedge clk);
            n++;
        end
        if ((hs_total - run_base) < cnt) begin
            checks++;
            fails++;
            $display("FAIL beat_wait: got %0d beats expected %0d", hs_total - run_base, cnt);
        end
    endtask

    initial begin
        beat_t e;
        int    rd_base;
        for (int i = 0; i < 128; i++) ram[i] = W'(i);
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_last", {31'd0, last}, 32'd0);
        chk("rst_is_vec", {31'd0, is_vec}, 32'd0);
        chk("rst_data", {12'd0, data}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ready held high, full stream in 72 consecutive cycles
        ready_val = 1'b1;
        repeat (2) @(posedge clk);
        run_base = hs_total;
        push_run();
        pulse_start();
        @(negedge clk);
        chk("t1_busy_high", {31'd0, busy}, 32'd1);
        wait_done("t1");
        chk("t1_first_latency", first_hs - start_cyc, 32'd2);
        chk("t1_burst_span", last_hs - first_hs, 32'd71);
        chk("t1_beats", hs_total - run_base, 32'd72);

        // 2: ready toggling
        ready_tog = 1'b1;
        run_base = hs_total;
        push_run();
        pulse_start();
        wait_done("t2");
        chk("t2_beats", hs_total - run_base, 32'd72);
        ready_tog = 1'b0;

        // 3: ready low for 20 cycles: only two reads, head holds addr 0
        ready_val = 1'b0;
        repeat (2) @(posedge clk);
        run_base = hs_total;
        push_run();
        rd_base = rd_issued;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("t3_reads", rd_issued - rd_base, 32'd2);
        chk("t3_valid", {31'd0, valid}, 32'd1);
        chk("t3_head", {12'd0, data}, 32'd0);
        ready_val = 1'b1;
        wait_done("t3");
        chk("t3_beats", hs_total - run_base, 32'd72);

        // 4: restart during stream is ignored, later start works
        run_base = hs_total;
        push_run();
        pulse_start();
        wait_beats(30);
        pulse_start();
        wait_done("t4a");
        chk("t4a_beats", hs_total - run_base, 32'd72);
        run_base = hs_total;
        push_run();
        pulse_start();
        wait_done("t4b");
        chk("t4b_beats", hs_total - run_base, 32'd72);

        // 5: reset mid-stream
        run_base = hs_total;
        push_run();
        pulse_start();
        wait_beats(40);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_last", {31'd0, last}, 32'd0);
        chk("t5_is_vec", {31'd0, is_vec}, 32'd0);
        chk("t5_data", {12'd0, data}, 32'd0);
        chk("t5_rd_en", {31'd0, rd_en}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_base = hs_total;
        push_run();
        pulse_start();
        wait_done("t5");
        chk("t5_beats", hs_total - run_base, 32'd72);

        // 6: saturation corner words on the first three eigenvalue addresses
        ram[0]  = 20'h08000;
        ram[8]  = 20'hF7FFF;
        ram[15] = 20'h01234;
        run_base = hs_total;
        push_run();
`ifdef JACOBI_UNLOAD_SAT_EN
        e = q[0];
        e.d = 20'h07FFF;
        q[0] = e;
        e = q[1];
        e.d = 20'hF8000;
        q[1] = e;
`endif
        pulse_start();
        wait_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
